puf_challenge_sequencer: RTL and testbench



---
 rtl/puf_challenge_sequencer_if.sv | 33 +++
 rtl/puf_challenge_sequencer.sv | 151 +++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_challenge_sequencer_if.sv
// Host-side bundle of the PUF challenge sequencer: run request, seed, status
// and the valid/ready response channel.
interface puf_challenge_sequencer_if #(
    parameter int CHAL_W    = 8,
    parameter int RESP_BITS = 16
);
    logic                 start;
    logic [CHAL_W-1:0]    seed;
    logic                 busy;
    logic [RESP_BITS-1:0] resp_word;
    logic                 resp_valid;
    logic                 resp_ready;

    // master: the host that requests runs and consumes response words
    modport master (
        output start,
        output seed,
        output resp_ready,
        input  busy,
        input  resp_word,
        input  resp_valid
    );

    // slave: the sequencer itself
    modport slave (
        input  start,
        input  seed,
        input  resp_ready,
        output busy,
        output resp_word,
        output resp_valid
    );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: expands a seed into LFSR challenges, fires one
// race per challenge, samples the synchronized outcome and returns a packed word.
module puf_challenge_sequencer #(
    parameter int               CHAL_W     = 8,
    parameter logic [CHAL_W-1:0] TAPS      = 8'hB8,
    parameter int               RESP_BITS  = 16,
    parameter int               SETTLE_CYC = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    puf_challenge_sequencer_if.slave     host,
    input  logic                         resp_in,
    output logic [CHAL_W-1:0]            chal,
    output logic                         launch
);
    localparam int PW = $clog2(SETTLE_CYC) + 1;
    localparam int BW = (RESP_BITS > 2) ? $clog2(RESP_BITS) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(SETTLE_CYC - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        FIRE,
        SAMPLE,
        DONE
    } stateT;

    stateT                stateReg;
    logic [CHAL_W-1:0]    lfsrReg;
    logic [CHAL_W-1:0]    lfsrNext;
    logic [CHAL_W-1:0]    tapTerm;
    logic                 feedback;
    logic [PW-1:0]        phaseCntReg;
    logic [BW-1:0]        bitCntReg;
    logic                 launchReg;
    logic                 busyReg;
    logic [RESP_BITS-1:0] wordReg;
    logic                 validReg;
    logic                 syncMetaReg;
    logic                 respSync;

    // Fibonacci feedback: parity of the tapped LFSR bits
    genvar gi;
    generate
        for (gi = 0; gi < CHAL_W; gi++) begin : gTap
            assign tapTerm[gi] = lfsrReg[gi] & TAPS[gi];
        end
    endgenerate

    assign feedback = ^tapTerm;
    assign lfsrNext = {lfsrReg[CHAL_W-2:0], feedback};

    assign chal            = lfsrReg;
    assign launch          = launchReg;
    assign host.busy       = busyReg;
    assign host.resp_word  = wordReg;
    assign host.resp_valid = validReg;

    // The race outcome is unrelated to clk, so it gets two flops before use
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncMetaReg <= 1'b0;
            respSync    <= 1'b0;
        end else begin
            syncMetaReg <= resp_in;
            respSync    <= syncMetaReg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg    <= IDLE;
            lfsrReg     <= '0;
            phaseCntReg <= '0;
            bitCntReg   <= '0;
            launchReg   <= 1'b0;
            busyReg     <= 1'b0;
            wordReg     <= '0;
            validReg    <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (host.start) begin
                        stateReg <= LOAD;
                        busyReg  <= 1'b1;
                    end
                end

                LOAD: begin
                    // An all-zero LFSR would lock up, so a zero seed becomes 1
                    lfsrReg     <= (host.seed == '0) ? CHAL_W'(1) : host.seed;
                    wordReg     <= '0;
                    bitCntReg   <= '0;
                    phaseCntReg <= PHASE_LAST;
                    launchReg   <= 1'b0;
                    stateReg    <= ARM;
                end

                ARM: begin
                    if (phaseCntReg == '0) begin
                        stateReg    <= FIRE;
                        launchReg   <= 1'b1;
                        phaseCntReg <= PHASE_LAST;
                    end else begin
                        phaseCntReg <= phaseCntReg - 1'b1;
                    end
                end

                FIRE: begin
                    if (phaseCntReg == '0) begin
                        stateReg <= SAMPLE;
                    end else begin
                        phaseCntReg <= phaseCntReg - 1'b1;
                    end
                end

                SAMPLE: begin
                    wordReg   <= {wordReg[RESP_BITS-2:0], respSync};
                    lfsrReg   <= lfsrNext;
                    bitCntReg <= bitCntReg + 1'b1;
                    launchReg <= 1'b0;
                    if (bitCntReg == BIT_LAST) begin
                        stateReg <= DONE;
                        validReg <= 1'b1;
                    end else begin
                        stateReg    <= ARM;
                        phaseCntReg <= PHASE_LAST;
                    end
                end

                DONE: begin
                    // start is deliberately not looked at here; only IDLE accepts runs
                    if (host.resp_ready) begin
                        validReg <= 1'b0;
                        busyReg  <= 1'b0;
                        stateReg <= IDLE;
                    end
                end

                default: begin
                    stateReg  <= IDLE;
                    launchReg <= 1'b0;
                    busyReg   <= 1'b0;
                    validReg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Randomized self-checking bench for puf_challenge_sequencer against a
// behavioural model of challenge order, launch timing and response packing.
module tb_puf_challenge_sequencer;
    localparam int CHAL_W    = 8;
    localparam int RESP_BITS = 16;
    localparam int S         = 4;
    localparam int P         = 2 * S + 1;
    localparam int LAT       = 1 + RESP_BITS * P;
    localparam logic [7:0] TAPS = 8'hB8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        resp_in = 1'b0;
    logic [7:0]  chal;
    logic        launch;

    puf_challenge_sequencer_if #(.CHAL_W(CHAL_W), .RESP_BITS(RESP_BITS)) host ();

    puf_challenge_sequencer #(
        .CHAL_W(CHAL_W), .TAPS(TAPS), .RESP_BITS(RESP_BITS), .SETTLE_CYC(S)
    ) dut (
        .clk(clk),
        .reset(reset),
        .host(host),
        .resp_in(resp_in),
        .chal(chal),
        .launch(launch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  chalTrace   [0:299];
    logic        launchTrace [0:299];
    int          runLatency;
    logic [15:0] runWord;

    // Reference: next challenge is the old one doubled plus tap parity
    function automatic logic [7:0] modelStep(input logic [7:0] x);
        int ones;
        logic [8:0] shifted;
        ones    = $countones(x & TAPS);
        shifted = {x, 1'b0};
        return shifted[7:0] | 8'(ones % 2);
    endfunction

    function automatic logic [7:0] modelChal(input logic [7:0] seedV, input int k);
        logic [7:0] x;
        x = (seedV == 8'h00) ? 8'h01 : seedV;
        for (int i = 0; i < k; i++) x = modelStep(x);
        return x;
    endfunction

    // c counts clock edges after the one that accepted start
    function automatic logic modelLaunch(input int c);
        if (c < 1 || c >= LAT) return 1'b0;
        return ((c - 1) % P) >= S;
    endfunction

    task automatic runCapture(input logic [7:0] seedV, input logic [15:0] pattern);
        host.seed  = seedV;
        host.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        host.start = 1'b0;
        chalTrace[0]   = chal;
        launchTrace[0] = launch;
        runLatency = -1;
        runWord    = 16'h0000;
        for (int c = 1; c < 300; c++) begin
            @(posedge clk);
            @(negedge clk);
            chalTrace[c]   = chal;
            launchTrace[c] = launch;
            if (((c - 1) % P) == 0 && ((c - 1) / P) < RESP_BITS)
                resp_in = pattern[15 - (c - 1) / P];
            if (host.resp_valid) begin
                runLatency = c;
                runWord    = host.resp_word;
                break;
            end
        end
    endtask

    task automatic releaseWord();
        host.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        host.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (chal !== 8'h00) begin errors++; $display("FAIL reset_chal got %h want 00", chal); end
        checks++; if (launch !== 1'b0) begin errors++; $display("FAIL reset_launch got %b want 0", launch); end
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", host.busy); end
        checks++; if (host.resp_word !== 16'h0000) begin errors++; $display("FAIL reset_word got %h want 0000", host.resp_word); end
        checks++; if (host.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", host.resp_valid); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", host.busy); end
        $display("test_reset done");
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] seedV;
        int stopAt;
        seedV  = 8'($urandom);
        stopAt = 1 + 5 * P + S + 1;
        resp_in    = 1'b1;
        host.seed  = seedV;
        host.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        host.start = 1'b0;
        repeat (stopAt) begin @(posedge clk); @(negedge clk); end
        checks++; if (launch !== 1'b1) begin errors++; $display("FAIL midrun_fire_launch got %b want 1", launch); end
        checks++; if (host.resp_word !== 16'h001F) begin errors++; $display("FAIL midrun_partial_word got %h want 001f", host.resp_word); end
        #1 reset = 1'b1;
        #1;
        checks++; if (chal !== 8'h00) begin errors++; $display("FAIL async_chal got %h want 00", chal); end
        checks++; if (launch !== 1'b0) begin errors++; $display("FAIL async_launch got %b want 0", launch); end
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", host.busy); end
        checks++; if (host.resp_word !== 16'h0000) begin errors++; $display("FAIL async_word got %h want 0000", host.resp_word); end
        checks++; if (host.resp_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", host.resp_valid); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        runCapture(seedV, 16'hFFFF);
        checks++; if (runLatency !== LAT) begin errors++; $display("FAIL rerun_latency got %0d want %0d", runLatency, LAT); end
        checks++; if (runWord !== 16'hFFFF) begin errors++; $display("FAIL rerun_word got %h want ffff", runWord); end
        releaseWord();
        $display("test_reset_mid_run seed=%h word=%h latency=%0d", seedV, runWord, runLatency);
    endtask

    task automatic test_seed_sequence();
        logic [7:0] expSeq [0:5];
        logic [15:0] pattern;
        logic [7:0] want;
        expSeq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
        pattern = 16'($urandom);
        runCapture(8'h01, pattern);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (chalTrace[1 + k * P] !== expSeq[k]) begin
                errors++; $display("FAIL seq_chal%0d got %h want %h", k, chalTrace[1 + k * P], expSeq[k]);
            end
        end
        // challenge may change only on entry to a new bit window
        for (int c = 1; c < LAT && c <= runLatency; c++) begin
            want = modelChal(8'h01, (c - 1) / P);
            checks++;
            if (chalTrace[c] !== want) begin
                errors++; $display("FAIL seq_chal_cycle%0d got %h want %h", c, chalTrace[c], want);
            end
        end
        checks++; if (runWord !== pattern) begin errors++; $display("FAIL seq_word got %h want %h", runWord, pattern); end
        releaseWord();
        $display("test_seed_sequence word=%h", runWord);
    endtask

    task automatic test_constant_response();
        logic [7:0] seedV;
        int rises;
        seedV = 8'($urandom);
        runCapture(seedV, 16'hFFFF);
        checks++; if (runWord !== 16'hFFFF) begin errors++; $display("FAIL const_word got %h want ffff", runWord); end
        checks++; if (runLatency !== LAT) begin errors++; $display("FAIL const_latency got %0d want %0d", runLatency, LAT); end
        rises = 0;
        for (int c = 1; c <= LAT && c <= runLatency; c++) begin
            if (launchTrace[c] === 1'b1 && launchTrace[c - 1] === 1'b0) rises++;
            checks++;
            if (launchTrace[c] !== modelLaunch(c)) begin
                errors++; $display("FAIL const_launch_cycle%0d got %b want %b", c, launchTrace[c], modelLaunch(c));
            end
        end
        checks++; if (rises !== RESP_BITS) begin errors++; $display("FAIL const_launch_rises got %0d want %0d", rises, RESP_BITS); end
        releaseWord();
        $display("test_constant_response seed=%h word=%h latency=%0d rises=%0d", seedV, runWord, runLatency, rises);
    endtask

    task automatic test_zero_seed();
        logic [15:0] pattern;
        pattern = 16'($urandom);
        runCapture(8'h00, pattern);
        checks++; if (chalTrace[1] !== 8'h01) begin errors++; $display("FAIL zero_chal0 got %h want 01", chalTrace[1]); end
        checks++; if (chalTrace[1 + P] !== 8'h02) begin errors++; $display("FAIL zero_chal1 got %h want 02", chalTrace[1 + P]); end
        checks++; if (chalTrace[1 + 2 * P] !== 8'h04) begin errors++; $display("FAIL zero_chal2 got %h want 04", chalTrace[1 + 2 * P]); end
        checks++; if (runWord !== pattern) begin errors++; $display("FAIL zero_word got %h want %h", runWord, pattern); end
        releaseWord();
        $display("test_zero_seed word=%h", runWord);
    endtask

    task automatic test_pattern();
        logic [7:0] seedV;
        seedV = 8'($urandom);
        runCapture(seedV, 16'hAAAA);
        checks++; if (runWord !== 16'hAAAA) begin errors++; $display("FAIL pattern_word got %h want aaaa", runWord); end
        releaseWord();
        $display("test_pattern seed=%h word=%h", seedV, runWord);
    endtask

    task automatic test_random_runs();
        logic [7:0]  seedV;
        logic [15:0] pattern;
        logic [7:0]  want;
        for (int r = 0; r < 6; r++) begin
            seedV   = 8'($urandom);
            pattern = 16'($urandom);
            runCapture(seedV, pattern);
            checks++; if (runWord !== pattern) begin errors++; $display("FAIL rand%0d_word got %h want %h", r, runWord, pattern); end
            checks++; if (runLatency !== LAT) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", r, runLatency, LAT); end
            for (int k = 0; k <= RESP_BITS; k++) begin
                want = modelChal(seedV, k);
                checks++;
                if (chalTrace[1 + k * P] !== want) begin
                    errors++; $display("FAIL rand%0d_chal%0d got %h want %h", r, k, chalTrace[1 + k * P], want);
                end
            end
            releaseWord();
            $display("test_random_runs run=%0d seed=%h pattern=%h word=%h", r, seedV, pattern, runWord);
        end
    endtask

    task automatic test_handshake();
        logic [7:0]  seedV;
        logic [15:0] pattern;
        seedV   = 8'($urandom);
        pattern = 16'($urandom);
        runCapture(seedV, pattern);
        checks++; if (runWord !== pattern) begin errors++; $display("FAIL hs_word got %h want %h", runWord, pattern); end
        for (int i = 0; i < 10; i++) begin
            host.start = (i == 3);
            @(posedge clk);
            @(negedge clk);
            checks++; if (host.resp_valid !== 1'b1) begin errors++; $display("FAIL hs_hold_valid%0d got %b want 1", i, host.resp_valid); end
            checks++; if (host.resp_word !== pattern) begin errors++; $display("FAIL hs_hold_word%0d got %h want %h", i, host.resp_word, pattern); end
            checks++; if (launch !== 1'b0) begin errors++; $display("FAIL hs_hold_launch%0d got %b want 0", i, launch); end
        end
        // start together with resp_ready in DONE must only return to IDLE
        host.start      = 1'b1;
        host.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        host.start      = 1'b0;
        host.resp_ready = 1'b0;
        checks++; if (host.resp_valid !== 1'b0) begin errors++; $display("FAIL hs_release_valid got %b want 0", host.resp_valid); end
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL hs_release_busy got %b want 0", host.busy); end
        repeat (3) @(negedge clk);
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL hs_no_queue_busy got %b want 0", host.busy); end
        checks++; if (host.resp_word !== pattern) begin errors++; $display("FAIL hs_idle_word got %h want %h", host.resp_word, pattern); end
        checks++; if (chal !== modelChal(seedV, RESP_BITS)) begin errors++; $display("FAIL hs_idle_chal got %h want %h", chal, modelChal(seedV, RESP_BITS)); end
        $display("test_handshake seed=%h word=%h", seedV, runWord);
    endtask

    initial begin
        host.start      = 1'b0;
        host.seed       = 8'h00;
        host.resp_ready = 1'b0;
        test_reset();
        test_reset_mid_run();
        test_seed_sequence();
        test_constant_response();
        test_zero_seed();
        test_pattern();
        test_random_runs();
        test_handshake();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
